// File: rtl/mod_add_sched.sv
// mod_add_sched: round-robin scheduler that shares one multi-cycle modular
// adder (enable/done handshake) among NREQ requesters of the MSM pipeline.
// One operation is in flight at a time: IDLE grants, BUSY drives the adder
// until done, RESP returns the captured result to the granted requester.
// Optional feature macro: MOD_ADD_SCHED_TIMEOUT_EN (aborts a BUSY phase that
// lasts TIMEOUT cycles with rsp_r=0, rsp_err=1). Without it rsp_err is 0.
module mod_add_sched #(
    parameter int NREQ    = 4,
    parameter int WIDTH   = 128,
    parameter int TIMEOUT = 1024
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NREQ-1:0]         req_valid,
    input  logic [NREQ*WIDTH-1:0]   req_a,
    input  logic [NREQ*WIDTH-1:0]   req_b,
    output logic [NREQ-1:0]         req_ready,
    output logic [NREQ-1:0]         rsp_valid,
    output logic [WIDTH-1:0]        rsp_r,
    output logic                    rsp_err,
    output logic [WIDTH-1:0]        ma_a,
    output logic [WIDTH-1:0]        ma_b,
    output logic                    ma_enable,
    input  logic [WIDTH-1:0]        ma_r,
    input  logic                    ma_done
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    // Elaboration-time sanity check of the configuration.
    if (NREQ < 2 || TIMEOUT < 1) begin : g_bad_cfg
        $error("mod_add_sched: NREQ must be >= 2 and TIMEOUT >= 1");
    end

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [PW-1:0]      r_ptr;
    logic [PW-1:0]      r_gnt;
    logic [WIDTH-1:0]   r_ma_a;
    logic [WIDTH-1:0]   r_ma_b;
    logic [WIDTH-1:0]   r_rsp_r;

    logic               w_gnt_any;
    logic [PW-1:0]      w_gnt_idx;
    logic [PW-1:0]      w_scan_idx;
    logic [WIDTH-1:0]   w_sel_a;
    logic [WIDTH-1:0]   w_sel_b;
    logic               w_accept;
    logic               w_capture;
    logic               w_abort;
    logic               w_expire;

    // Round-robin search: first valid requester at or after the pointer, wrapping.
    always_comb begin
        w_gnt_any  = 1'b0;
        w_gnt_idx  = '0;
        w_scan_idx = '0;
        for (int j = 0; j < NREQ; j++) begin
            w_scan_idx = PW'((int'(r_ptr) + j) % NREQ);
            if (!w_gnt_any && req_valid[w_scan_idx]) begin
                w_gnt_any = 1'b1;
                w_gnt_idx = w_scan_idx;
            end
        end
    end

    // Operand mux selecting the granted requester's slices.
    always_comb begin
        w_sel_a = '0;
        w_sel_b = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_gnt_idx == PW'(i)) begin
                w_sel_a = req_a[i*WIDTH +: WIDTH];
                w_sel_b = req_b[i*WIDTH +: WIDTH];
            end
        end
    end

`ifdef MOD_ADD_SCHED_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0]      r_tcnt;
    logic               r_rsp_err;

    // The last permitted BUSY cycle is the one where the count reads TIMEOUT-1.
    assign w_expire = (r_state == S_BUSY) && (r_tcnt == CW'(TIMEOUT - 1));

    // BUSY-cycle counter: held at zero outside an operation so it starts clean.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_tcnt <= '0;
        end else if (r_state == S_BUSY) begin
            r_tcnt <= r_tcnt + CW'(1);
        end else begin
            r_tcnt <= '0;
        end
    end

    // Error flag accompanies the captured result; an adder done clears it.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rsp_err <= 1'b0;
        end else if (w_capture) begin
            r_rsp_err <= 1'b0;
        end else if (w_abort) begin
            r_rsp_err <= 1'b1;
        end
    end

    assign rsp_err = r_rsp_err;
`else
    assign w_expire = 1'b0;
    assign rsp_err  = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and handshake outputs; done outside BUSY is ignored by construction.
    always_comb begin
        w_state_nxt = r_state;
        req_ready   = '0;
        rsp_valid   = '0;
        ma_enable   = 1'b0;
        w_accept    = 1'b0;
        w_capture   = 1'b0;
        w_abort     = 1'b0;
        case (r_state)
            S_IDLE: begin
                // Gated with reset so a grant is never shown that will not be latched.
                if (w_gnt_any && !reset) begin
                    req_ready[w_gnt_idx] = 1'b1;
                    w_accept             = 1'b1;
                    w_state_nxt          = S_BUSY;
                end
            end
            S_BUSY: begin
                ma_enable = 1'b1;
                // A done on the expiry cycle wins over the abort.
                if (ma_done) begin
                    w_capture   = 1'b1;
                    w_state_nxt = S_RESP;
                end else if (w_expire) begin
                    w_abort     = 1'b1;
                    w_state_nxt = S_RESP;
                end
            end
            S_RESP: begin
                rsp_valid[r_gnt] = 1'b1;
                w_state_nxt      = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Operand latch, grant bookkeeping, round-robin pointer and result capture.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ma_a  <= '0;
            r_ma_b  <= '0;
            r_rsp_r <= '0;
            r_gnt   <= '0;
            r_ptr   <= '0;
        end else begin
            if (w_accept) begin
                r_ma_a <= w_sel_a;
                r_ma_b <= w_sel_b;
                r_gnt  <= w_gnt_idx;
                r_ptr  <= (w_gnt_idx == PW'(NREQ - 1)) ? '0 : w_gnt_idx + PW'(1);
            end
            if (w_capture) begin
                r_rsp_r <= ma_r;
            end else if (w_abort) begin
                r_rsp_r <= '0;
            end
        end
    end

    assign ma_a  = r_ma_a;
    assign ma_b  = r_ma_b;
    assign rsp_r = r_rsp_r;

endmodule

// File: tb/tb_mod_add_sched.sv
// Scoreboard bench for mod_add_sched with a behavioural modular adder (p=37)
// whose done latency k_cyc is set per test (0 = never done).
`timescale 1ns/1ps
module tb_mod_add_sched;

    localparam int NREQ = 4;
    localparam int W    = 128;
    localparam int TO   = 16;
    localparam int P    = 37;

    logic                 clk = 1'b0;
    logic                 reset;
    logic [NREQ-1:0]      req_valid;
    logic [NREQ*W-1:0]    req_a;
    logic [NREQ*W-1:0]    req_b;
    logic [NREQ-1:0]      req_ready;
    logic [NREQ-1:0]      rsp_valid;
    logic [W-1:0]         rsp_r;
    logic                 rsp_err;
    logic [W-1:0]         ma_a;
    logic [W-1:0]         ma_b;
    logic                 ma_enable;
    logic [W-1:0]         ma_r;
    logic                 ma_done;

    int n_cmp = 0;
    int n_bad = 0;

    int   k_cyc;
    logic force_done;
    int   a_cnt = 0;

    typedef struct {
        int         g;
        logic [W-1:0] r;
        logic       e;
    } rsp_t;

    rsp_t q_rsp[$];
    int   q_gnt[$];

    always #5 clk = ~clk;

    mod_add_sched #(.NREQ(NREQ), .WIDTH(W), .TIMEOUT(TO)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_r     (rsp_r),
        .rsp_err   (rsp_err),
        .ma_a      (ma_a),
        .ma_b      (ma_b),
        .ma_enable (ma_enable),
        .ma_r      (ma_r),
        .ma_done   (ma_done)
    );

    // Behavioural adder: done in the k-th enabled cycle, result (a+b) mod p.
    always @(posedge clk) begin
        if (!ma_enable || ma_done) a_cnt <= 0;
        else                       a_cnt <= a_cnt + 1;
    end
    assign ma_done = force_done | (ma_enable && k_cyc > 0 && a_cnt == k_cyc - 1);
    assign ma_r    = (ma_a + ma_b) % W'(P);

    task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, required %0h", nm, act, exp);
        end
    endtask

    task automatic exp_op(input int g, input logic [W-1:0] r, input logic e);
        q_gnt.push_back(g);
        q_rsp.push_back('{g: g, r: r, e: e});
    endtask

    task automatic wait_rsps(input int n, input int budget, input string nm);
        int seen = 0;
        int t = 0;
        while (seen < n && t < budget) begin
            @(negedge clk);
            t++;
            if (rsp_valid != '0) seen++;
        end
        n_cmp++;
        if (seen < n) begin
            n_bad++;
            $display("FAIL %s_wait: saw %0d responses, required %0d", nm, seen, n);
        end
    endtask

    // Monitor: pops expected grants/responses whenever the DUT presents them.
    always @(negedge clk) begin
        rsp_t e;
        int   g;
        if (!reset) begin
            if (req_ready != '0) begin
                if (q_gnt.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL unexpected_grant: req_ready=%b, required none", req_ready);
                end else begin
                    g = q_gnt.pop_front();
                    chk("grant", W'(req_ready), W'(1) << g);
                end
            end
            if (rsp_valid != '0) begin
                if (q_rsp.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL unexpected_rsp: rsp_valid=%b, required none", rsp_valid);
                end else begin
                    e = q_rsp.pop_front();
                    chk("rsp_valid", W'(rsp_valid), W'(1) << e.g);
                    chk("rsp_r", rsp_r, e.r);
                    chk("rsp_err", W'(rsp_err), W'(e.e));
                end
            end
            if (ma_enable || rsp_valid != '0)
                chk("ready_while_busy", W'(req_ready), '0);
        end
    end

    initial begin
        reset = 1'b1; req_valid = '0; req_a = '0; req_b = '0;
        k_cyc = 3; force_done = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        // Reset state
        @(negedge clk);
        chk("rst_req_ready", W'(req_ready), '0);
        chk("rst_rsp_valid", W'(rsp_valid), '0);
        chk("rst_ma_enable", W'(ma_enable), '0);
        chk("rst_rsp_err", W'(rsp_err), '0);
        chk("rst_ma_a", ma_a, '0);
        chk("rst_ma_b", ma_b, '0);
        chk("rst_rsp_r", rsp_r, '0);

        // Single op: 5+35 mod 37 = 3, done after 3 enable cycles
        @(posedge clk); #1;
        reset = 1'b0;
        req_a[0*W +: W] = 5; req_b[0*W +: W] = 35; k_cyc = 3;
        exp_op(0, 3, 1'b0);
        req_valid = 4'b0001;
        @(negedge clk);
        chk("single_ready_c0", W'(req_ready), 1);
        chk("single_en_c0", W'(ma_enable), 0);
        @(posedge clk); #1;
        req_valid = '0;
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            chk("single_en_busy", W'(ma_enable), 1);
        end
        @(negedge clk);
        chk("single_rsp_valid_c4", W'(rsp_valid), 1);
        chk("single_rsp_r_c4", rsp_r, 3);
        chk("single_en_c4", W'(ma_enable), 0);
        chk("single_ma_a", ma_a, 5);
        chk("single_ma_b", ma_b, 35);

        // Spurious done while IDLE
        @(posedge clk); #1;
        force_done = 1'b1;
        repeat (2) begin
            @(negedge clk);
            chk("spurious_rsp_valid", W'(rsp_valid), 0);
            chk("spurious_en", W'(ma_enable), 0);
        end
        @(posedge clk); #1;
        force_done = 1'b0;
        @(negedge clk);
        chk("spurious_rsp_r_held", rsp_r, 3);

        // Contention 1010 with pointer at 1: grants 1,3,1
        @(posedge clk); #1;
        k_cyc = 1;
        req_a[1*W +: W] = 10; req_b[1*W +: W] = 30;
        req_a[3*W +: W] = 36; req_b[3*W +: W] = 36;
        exp_op(1, 3, 1'b0);
        exp_op(3, 35, 1'b0);
        exp_op(1, 3, 1'b0);
        req_valid = 4'b1010;
        wait_rsps(3, 40, "contention");
        @(posedge clk); #1;
        req_valid = '0;
        @(negedge clk);
        chk("contention_released", W'(req_ready), 0);

        // Reset on the 2nd BUSY cycle
        @(posedge clk); #1;
        k_cyc = 5;
        req_a[1*W +: W] = 7; req_b[1*W +: W] = 8;
        q_gnt.push_back(1);
        req_valid = 4'b0010;
        @(posedge clk); #1;
        req_valid = '0;
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        chk("mid_rst_req_ready", W'(req_ready), 0);
        chk("mid_rst_rsp_valid", W'(rsp_valid), 0);
        chk("mid_rst_ma_enable", W'(ma_enable), 0);
        chk("mid_rst_rsp_err", W'(rsp_err), 0);
        chk("mid_rst_ma_a", ma_a, 0);
        chk("mid_rst_ma_b", ma_b, 0);
        chk("mid_rst_rsp_r", rsp_r, 0);
        @(posedge clk); #1;
        k_cyc = 2;
        req_a[2*W +: W] = 20; req_b[2*W +: W] = 20;
        exp_op(2, 3, 1'b0);
        req_valid = 4'b0100;
        @(negedge clk);
        chk("post_rst_ready", W'(req_ready), 4);
        @(posedge clk); #1;
        req_valid = '0;
        wait_rsps(1, 20, "post_rst");

        // Fairness: reset pointer, all four valid for 8 ops
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        k_cyc = 2;
        for (int i = 0; i < NREQ; i++) begin
            req_a[i*W +: W] = W'(10 * (i + 1));
            req_b[i*W +: W] = 30;
        end
        for (int n = 0; n < 2; n++) begin
            exp_op(0, 3, 1'b0);
            exp_op(1, 13, 1'b0);
            exp_op(2, 23, 1'b0);
            exp_op(3, 33, 1'b0);
        end
        req_valid = 4'b1111;
        wait_rsps(8, 100, "fairness");
        @(posedge clk); #1;
        req_valid = '0;

        // Timeout: adder never signals done
        @(posedge clk); #1;
        k_cyc = 0;
        req_a[0*W +: W] = 1; req_b[0*W +: W] = 2;
`ifdef MOD_ADD_SCHED_TIMEOUT_EN
        exp_op(0, 0, 1'b1);
        req_valid = 4'b0001;
        @(posedge clk); #1;
        req_valid = '0;
        for (int c = 1; c <= TO; c++) begin
            @(negedge clk);
            chk("timeout_busy_en", W'(ma_enable), 1);
        end
        @(negedge clk);
        chk("timeout_rsp_valid", W'(rsp_valid), 1);
        chk("timeout_en_dropped", W'(ma_enable), 0);
`else
        q_gnt.push_back(0);
        req_valid = 4'b0001;
        @(posedge clk); #1;
        req_valid = '0;
        repeat (30) @(negedge clk);
        chk("no_timeout_busy_en", W'(ma_enable), 1);
        chk("no_timeout_rsp_valid", W'(rsp_valid), 0);
        exp_op(0, 3, 1'b0);
        q_gnt.pop_back();
        @(posedge clk); #1;
        force_done = 1'b1;
        @(posedge clk); #1;
        force_done = 1'b0;
        @(negedge clk);
        chk("late_done_rsp_valid", W'(rsp_valid), 1);
`endif

        repeat (3) @(posedge clk);
        #1;
        chk("gnt_queue_drained", W'(q_gnt.size()), 0);
        chk("rsp_queue_drained", W'(q_rsp.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
